output_data_sequencer: RTL and testbench
========================================

OUTPUT_DATA_SEQUENCER -- requirements
Module: output_data_sequencer

Interface
REQ-001 The block SHALL have parameter IDLE_DB, default 8'h00, which is the db_out value whenever no byte is being driven.
REQ-002 The block SHALL have port fclk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit, the transfer start request.
REQ-005 The block SHALL have port two_byte, input, 1 bit, sampled at load: 1 sends two bytes, 0 sends the low byte only.
REQ-006 The block SHALL have port high_first, input, 1 bit, sampled at load: 1 sends high then low (stack-push order), 0 sends low then high (little-endian).
REQ-007 The block SHALL have port data_in, input, 16 bits, the word to send as {high, low}.
REQ-008 The block SHALL have port rdy, input, 1 bit, the bus-ready signal: 0 stalls the current byte.
REQ-009 The block SHALL have port db_out, output, 8 bits, the data bus byte.
REQ-010 The block SHALL have port rwb, output, 1 bit, read/write: 0 while a write byte is driven, 1 otherwise.
REQ-011 The block SHALL have port byte_sel, output, 1 bit, which byte is on db_out: 0 low, 1 high.
REQ-012 The block SHALL have port busy, output, 1 bit, which is 1 while in BYTE0 or BYTE1.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-014 The state machine SHALL have exactly the states IDLE, BYTE0 and BYTE1; all outputs SHALL be registered or decoded from registered state only.
REQ-015 In IDLE, a rising edge with load=1 SHALL capture data_in, two_byte and high_first into internal registers and move to BYTE0.
REQ-016 The first byte SHALL appear on db_out with rwb=0 and busy=1 in the cycle immediately after the load edge, giving a latency of 1 cycle.
REQ-017 BYTE0 SHALL drive the high byte (byte_sel=1) when high_first=1 and two_byte=1, and the low byte (byte_sel=0) otherwise.
REQ-018 BYTE1 SHALL drive the byte not sent in BYTE0, with byte_sel set to match.
REQ-019 A byte SHALL complete on a rising edge with rdy=1; while rdy=0 the state, db_out, byte_sel and rwb SHALL hold unchanged.
REQ-020 On completion of BYTE0, the block SHALL go to BYTE1 if two_byte=1 and to IDLE otherwise; on completion of BYTE1 it SHALL go to IDLE.
REQ-021 done SHALL be 1 for exactly the one cycle following the final byte completion, in IDLE, and 0 at all other times.
REQ-022 In IDLE: db_out=IDLE_DB, rwb=1, busy=0, byte_sel=0.
REQ-023 load while busy=1 SHALL be ignored, with no effect on captured data or sequence.
REQ-024 load in the done cycle SHALL be accepted, so back-to-back transfers run with exactly one IDLE cycle between them.
REQ-025 Changes to data_in, two_byte or high_first after the load edge SHALL have no effect on the transfer in progress.
REQ-026 When two_byte=0, high_first SHALL be ignored and only the low byte is sent.

Reset
REQ-027 While clear=1, regardless of fclk: state=IDLE, db_out=IDLE_DB, rwb=1, byte_sel=0, busy=0, done=0, and captured registers=0.
REQ-028 clear asserted mid-transfer SHALL abort immediately with no done pulse; the first edge after clear falls SHALL behave as IDLE.

Verification
REQ-029 The bench SHALL cover: load with data_in=16'hA55A, two_byte=1, high_first=0, rdy=1 -> db_out 8'h5A (byte_sel=0, rwb=0), then 8'hA5 (byte_sel=1), then done=1 with rwb=1 and db_out=8'h00.
REQ-030 The bench SHALL cover: data_in=16'h1234, two_byte=1, high_first=1 -> 8'h12 then 8'h34, then done pulse; total 3 cycles from the load edge to the done cycle.
REQ-031 The bench SHALL cover: data_in=16'hBEEF, two_byte=0, high_first=1 -> single byte 8'hEF with byte_sel=0, then done.
REQ-032 The bench SHALL cover: rdy=0 for 3 cycles during byte 8'h5A, with data_in changed to 16'hFFFF and load pulsed -> 8'h5A held 4 cycles, then 8'hA5, one done pulse only.
REQ-033 The bench SHALL cover: clear pulsed during BYTE1 -> outputs at reset values asynchronously, no done; a subsequent load of 16'h00C3 with two_byte=0 -> 8'hC3.
REQ-034 The bench SHALL cover: load held high continuously with 16'h0102 and 16'h0304 -> 02, 01, idle+done, 04, 03, idle+done.

Source files
------------

// File: rtl/output_data_sequencer.sv
// Byte-serial output sequencer: sends one or two bytes of a captured 16-bit word
// onto an 8-bit bus, stalling on rdy and pulsing done after the last byte.
module output_data_sequencer #(
    parameter logic [7:0] IDLE_DB = 8'h00
) (
    input  logic        fclk,
    input  logic        clear,
    input  logic        load,
    input  logic        two_byte,
    input  logic        high_first,
    input  logic [15:0] data_in,
    input  logic        rdy,
    output logic [7:0]  db_out,
    output logic        rwb,
    output logic        byte_sel,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BYTE0 = 2'd1;
    localparam logic [1:0] BYTE1 = 2'd2;

    logic [1:0]  state;
    logic [15:0] data_q;
    logic        two_byte_q;
    logic        high_first_q;
    logic        first_is_high;

    // high_first only matters for two-byte transfers; single transfers send the low byte
    assign first_is_high = two_byte_q & high_first_q;

    always_ff @(posedge fclk or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            data_q       <= 16'h0000;
            two_byte_q   <= 1'b0;
            high_first_q <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        data_q       <= data_in;
                        two_byte_q   <= two_byte;
                        high_first_q <= high_first;
                        state        <= BYTE0;
                    end
                end
                BYTE0: begin
                    if (rdy) begin
                        if (two_byte_q) begin
                            state <= BYTE1;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                BYTE1: begin
                    if (rdy) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state == BYTE0) || (state == BYTE1);
        byte_sel = 1'b0;
        if (state == BYTE0) begin
            byte_sel = first_is_high;
        end else if (state == BYTE1) begin
            byte_sel = ~first_is_high;
        end
        db_out = IDLE_DB;
        if (busy) begin
            db_out = byte_sel ? data_q[15:8] : data_q[7:0];
        end
        rwb = ~busy;
    end

endmodule

// File: tb/tb_output_data_sequencer.sv
// Directed and randomized checks of output_data_sequencer against a
// queue-of-pending-bytes reference model.
module tb_output_data_sequencer;

    logic        fclk = 1'b0;
    logic        clear;
    logic        load;
    logic        two_byte;
    logic        high_first;
    logic [15:0] data_in;
    logic        rdy;
    logic [7:0]  db_out;
    logic        rwb;
    logic        byte_sel;
    logic        busy;
    logic        done;

    int compared = 0;
    int mismatched = 0;

    // Model: bytes still to be sent, each entry {byte_sel, value}
    logic [8:0] pend[$];
    logic       done_m;

    output_data_sequencer #(.IDLE_DB(8'h00)) dut (
        .fclk(fclk), .clear(clear), .load(load), .two_byte(two_byte),
        .high_first(high_first), .data_in(data_in), .rdy(rdy),
        .db_out(db_out), .rwb(rwb), .byte_sel(byte_sel), .busy(busy), .done(done)
    );

    always #5 fclk = ~fclk;

    task automatic drive(input logic l, input logic t, input logic h,
                         input logic [15:0] d, input logic r);
        load = l; two_byte = t; high_first = h; data_in = d; rdy = r;
    endtask

    task automatic model_reset();
        pend.delete();
        done_m = 1'b0;
    endtask

    // Advance the model by one rising edge using the input values present at it
    task automatic model_edge();
        done_m = 1'b0;
        if (pend.size() != 0) begin
            if (rdy) begin
                void'(pend.pop_front());
                if (pend.size() == 0) done_m = 1'b1;
            end
        end else if (load) begin
            if (!two_byte) begin
                pend.push_back({1'b0, data_in[7:0]});
            end else if (high_first) begin
                pend.push_back({1'b1, data_in[15:8]});
                pend.push_back({1'b0, data_in[7:0]});
            end else begin
                pend.push_back({1'b0, data_in[7:0]});
                pend.push_back({1'b1, data_in[15:8]});
            end
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] e_db;
        logic       e_sel;
        logic       e_busy;
        if (pend.size() != 0) begin
            e_db = pend[0][7:0]; e_sel = pend[0][8]; e_busy = 1'b1;
        end else begin
            e_db = 8'h00; e_sel = 1'b0; e_busy = 1'b0;
        end
        chk8({tag, ".db_out"}, db_out, e_db);
        chk1({tag, ".byte_sel"}, byte_sel, e_sel);
        chk1({tag, ".busy"}, busy, e_busy);
        chk1({tag, ".rwb"}, rwb, ~e_busy);
        chk1({tag, ".done"}, done, done_m);
    endtask

    task automatic step(input string tag);
        @(posedge fclk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk8({tag, ".db_out"}, db_out, 8'h00);
        chk1({tag, ".rwb"}, rwb, 1'b1);
        chk1({tag, ".byte_sel"}, byte_sel, 1'b0);
        chk1({tag, ".busy"}, busy, 1'b0);
        chk1({tag, ".done"}, done, 1'b0);
    endtask

    initial begin
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        model_reset();
        #12;
        check_reset_outputs("reset");
        clear = 1'b0;
        step("idle0");

        // Little-endian two-byte transfer
        drive(1'b1, 1'b1, 1'b0, 16'hA55A, 1'b1);
        step("le_b0");
        chk8("le_b0_val", db_out, 8'h5A);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("le_b1");
        chk8("le_b1_val", db_out, 8'hA5);
        chk1("le_b1_sel", byte_sel, 1'b1);
        step("le_done");
        chk1("le_done_pulse", done, 1'b1);
        step("le_after");
        chk1("le_done_clear", done, 1'b0);

        // High-first two-byte transfer, 3 cycles from load edge to done
        drive(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        step("hf_b0");
        chk8("hf_b0_val", db_out, 8'h12);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("hf_b1");
        chk8("hf_b1_val", db_out, 8'h34);
        step("hf_done");
        chk1("hf_done_at3", done, 1'b1);

        // Single byte: high_first ignored
        drive(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1);
        step("sb_b0");
        chk8("sb_val", db_out, 8'hEF);
        chk1("sb_sel", byte_sel, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("sb_done");
        chk1("sb_done_pulse", done, 1'b1);

        // Stall on rdy with disturbing inputs
        drive(1'b1, 1'b1, 1'b0, 16'hA55A, 1'b0);
        step("st_b0");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
            step("st_hold");
            chk8("st_hold_val", db_out, 8'h5A);
        end
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        step("st_b1");
        chk8("st_b1_val", db_out, 8'hA5);
        step("st_done");
        chk1("st_done_pulse", done, 1'b1);
        step("st_after");
        chk1("st_single_done", done, 1'b0);

        // Asynchronous clear during BYTE1
        drive(1'b1, 1'b1, 1'b0, 16'hA55A, 1'b1);
        step("cl_b0");
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("cl_b1");
        #2 clear = 1'b1;
        #1;
        check_reset_outputs("cl_async");
        model_reset();
        clear = 1'b0;
        step("cl_idle");
        drive(1'b1, 1'b0, 1'b0, 16'h00C3, 1'b1);
        step("cl_reload");
        chk8("cl_reload_val", db_out, 8'hC3);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("cl_done");

        // Back-to-back with load held high
        drive(1'b1, 1'b1, 1'b0, 16'h0102, 1'b1);
        step("bb_02");
        chk8("bb_02_val", db_out, 8'h02);
        data_in = 16'h0304;
        step("bb_01");
        chk8("bb_01_val", db_out, 8'h01);
        step("bb_done1");
        chk1("bb_done1_pulse", done, 1'b1);
        step("bb_04");
        chk8("bb_04_val", db_out, 8'h04);
        step("bb_03");
        chk8("bb_03_val", db_out, 8'h03);
        load = 1'b0;
        step("bb_done2");
        chk1("bb_done2_pulse", done, 1'b1);

        // Randomized traffic with occasional asynchronous clears
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                  16'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 49) == 0) begin
                #2 clear = 1'b1;
                #1;
                check_reset_outputs("rnd_clear");
                model_reset();
                clear = 1'b0;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
